// File: rtl/pb_tap_pkg.sv
// Shared types and default opcodes for the TAP controller and the DR mux.
package pb_tap_pkg;

    typedef enum logic [3:0] {
        StTlr,
        StRti,
        StSelDr,
        StCapDr,
        StShDr,
        StEx1Dr,
        StPaDr,
        StEx2Dr,
        StUpdDr,
        StSelIr,
        StCapIr,
        StShIr,
        StEx1Ir,
        StPaIr,
        StEx2Ir,
        StUpdIr
    } tap_state_e;

    typedef enum logic [1:0] {
        SEL_ZERO = 2'b00,
        SEL_DR   = 2'b01,
        SEL_SCAN = 2'b10,
        SEL_BYP  = 2'b11
    } tdo_sel_e;

    localparam logic [3:0] IDCODE_INSTR_DEF = 4'b0001;
    localparam logic [3:0] SCAN_INSTR_DEF   = 4'b0010;
    localparam logic [3:0] BYPASS_INSTR_DEF = 4'b1111;

endpackage

// File: rtl/pb_tap_ir.sv
// TAP instruction register: capture/shift/update stages plus decode to the DR mux select.
module pb_tap_ir
    import pb_tap_pkg::*;
#(
    parameter int unsigned         IR_WIDTH     = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(IDCODE_INSTR_DEF),
    parameter logic [IR_WIDTH-1:0] SCAN_INSTR   = IR_WIDTH'(SCAN_INSTR_DEF),
    parameter logic [IR_WIDTH-1:0] RESET_INSTR  = IR_WIDTH'(BYPASS_INSTR_DEF)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tdi_i,
    input  logic                capture_i,
    input  logic                shift_i,
    input  logic                update_i,
    input  logic                tlr_load_i,
    input  logic                dr_active_i,
    output logic                tdo_o,
    output tdo_sel_e            sel_o,
    output logic [IR_WIDTH-1:0] ir_o
);

    localparam logic [IR_WIDTH-1:0] CAPTURE_VAL = IR_WIDTH'(2'b01);

    logic [IR_WIDTH-1:0] sreg_q, sreg_d;
    logic [IR_WIDTH-1:0] ir_q, ir_d;

    always_comb begin
        sreg_d = sreg_q;
        if (capture_i) begin
            sreg_d = CAPTURE_VAL;
        end else if (shift_i) begin
            sreg_d = {tdi_i, sreg_q[IR_WIDTH-1:1]};
        end
    end

    // Reaching Test-Logic-Reset wins over any pending update.
    always_comb begin
        ir_d = ir_q;
        if (tlr_load_i) begin
            ir_d = RESET_INSTR;
        end else if (update_i) begin
            ir_d = sreg_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sreg_q <= '0;
            ir_q   <= RESET_INSTR;
        end else begin
            sreg_q <= sreg_d;
            ir_q   <= ir_d;
        end
    end

    always_comb begin
        sel_o = SEL_ZERO;
        if (dr_active_i) begin
            if (ir_q == IDCODE_INSTR) begin
                sel_o = SEL_DR;
            end else if (ir_q == SCAN_INSTR) begin
                sel_o = SEL_SCAN;
            end else begin
                sel_o = SEL_BYP;
            end
        end
    end

    assign tdo_o = sreg_q[0];
    assign ir_o  = ir_q;

endmodule

// File: rtl/pb_tap_ctrl.sv
// IEEE 1149.1 TAP controller: 16-state FSM, instruction register and DR strobes.
// Define PB_TAP_IDCODE_DEFAULT_EN to make IDCODE the reset instruction instead of BYPASS.
module pb_tap_ctrl
    import pb_tap_pkg::*;
#(
    parameter int unsigned         IR_WIDTH     = 4,
    parameter logic [IR_WIDTH-1:0] IDCODE_INSTR = IR_WIDTH'(IDCODE_INSTR_DEF),
    parameter logic [IR_WIDTH-1:0] SCAN_INSTR   = IR_WIDTH'(SCAN_INSTR_DEF),
    parameter logic [IR_WIDTH-1:0] BYPASS_INSTR = {IR_WIDTH{1'b1}}
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                tms_i,
    input  logic                tdi_i,
    output logic [1:0]          sel_o,
    output logic                capture_dr_o,
    output logic                shift_dr_o,
    output logic                update_dr_o,
    output logic                tlr_o,
    output logic                ir_shift_o,
    output logic                ir_tdo_o,
    output logic [IR_WIDTH-1:0] ir_o
);

`ifdef PB_TAP_IDCODE_DEFAULT_EN
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = IDCODE_INSTR;
`else
    localparam logic [IR_WIDTH-1:0] RESET_INSTR = BYPASS_INSTR;
`endif

    tap_state_e state_q, state_d;
    tdo_sel_e   sel;
    logic       dr_active;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTlr:   state_d = tms_i ? StTlr   : StRti;
            StRti:   state_d = tms_i ? StSelDr : StRti;
            StSelDr: state_d = tms_i ? StSelIr : StCapDr;
            StCapDr: state_d = tms_i ? StEx1Dr : StShDr;
            StShDr:  state_d = tms_i ? StEx1Dr : StShDr;
            StEx1Dr: state_d = tms_i ? StUpdDr : StPaDr;
            StPaDr:  state_d = tms_i ? StEx2Dr : StPaDr;
            StEx2Dr: state_d = tms_i ? StUpdDr : StShDr;
            StUpdDr: state_d = tms_i ? StSelDr : StRti;
            StSelIr: state_d = tms_i ? StTlr   : StCapIr;
            StCapIr: state_d = tms_i ? StEx1Ir : StShIr;
            StShIr:  state_d = tms_i ? StEx1Ir : StShIr;
            StEx1Ir: state_d = tms_i ? StUpdIr : StPaIr;
            StPaIr:  state_d = tms_i ? StEx2Ir : StPaIr;
            StEx2Ir: state_d = tms_i ? StUpdIr : StShIr;
            StUpdIr: state_d = tms_i ? StSelDr : StRti;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StTlr;
        end else begin
            state_q <= state_d;
        end
    end

    assign dr_active = (state_q inside {StCapDr, StShDr, StEx1Dr, StPaDr, StEx2Dr, StUpdDr});

    pb_tap_ir #(
        .IR_WIDTH     (IR_WIDTH),
        .IDCODE_INSTR (IDCODE_INSTR),
        .SCAN_INSTR   (SCAN_INSTR),
        .RESET_INSTR  (RESET_INSTR)
    ) u_ir (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .tdi_i       (tdi_i),
        .capture_i   (state_q == StCapIr),
        .shift_i     (state_q == StShIr),
        .update_i    (state_q == StUpdIr),
        .tlr_load_i  (state_d == StTlr),
        .dr_active_i (dr_active),
        .tdo_o       (ir_tdo_o),
        .sel_o       (sel),
        .ir_o        (ir_o)
    );

    assign sel_o        = sel;
    assign capture_dr_o = (state_q == StCapDr);
    assign shift_dr_o   = (state_q == StShDr);
    assign update_dr_o  = (state_q == StUpdDr);
    assign tlr_o        = (state_q == StTlr);
    assign ir_shift_o   = (state_q == StShIr);

endmodule

// File: tb/tb_pb_tap_ctrl.sv
// Bench for pb_tap_ctrl: directed vector table, corner sequences and random TMS/TDI vs a model.
module tb_pb_tap_ctrl;

`ifdef PB_TAP_IDCODE_DEFAULT_EN
    localparam logic [3:0] RST_OP  = 4'b0001;
    localparam logic [1:0] RST_SEL = 2'b01;
`else
    localparam logic [3:0] RST_OP  = 4'b1111;
    localparam logic [1:0] RST_SEL = 2'b11;
`endif

    logic       clk = 1'b0;
    logic       rst, tms, tdi;
    logic [1:0] sel;
    logic       cap, shdr, upd, tlr, irsh, tdo;
    logic [3:0] ir;

    always #5 clk = ~clk;

    pb_tap_ctrl dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tms_i        (tms),
        .tdi_i        (tdi),
        .sel_o        (sel),
        .capture_dr_o (cap),
        .shift_dr_o   (shdr),
        .update_dr_o  (upd),
        .tlr_o        (tlr),
        .ir_shift_o   (irsh),
        .ir_tdo_o     (tdo),
        .ir_o         (ir)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: states numbered in the order of the standard state list.
    localparam int M_TLR = 0, M_SH_DR = 4, M_UPD_DR = 8, M_CAP_IR = 10, M_SH_IR = 11;
    localparam int M_UPD_IR = 15, M_CAP_DR = 3;
    int nxt0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
    int nxt1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
    int         ms;
    logic [3:0] msreg, mir;

    task automatic model_reset();
        ms = M_TLR;
        msreg = 4'b0000;
        mir = RST_OP;
    endtask

    task automatic model_clock(input logic t, input logic d);
        int ns;
        ns = t ? nxt1[ms] : nxt0[ms];
        if (ns == M_TLR) mir = RST_OP;
        else if (ms == M_UPD_IR) mir = msreg;
        if (ms == M_CAP_IR) msreg = 4'b0001;
        else if (ms == M_SH_IR) msreg = {d, msreg[3:1]};
        ms = ns;
    endtask

    function automatic logic [1:0] model_sel();
        if (ms < M_CAP_DR || ms > M_UPD_DR) return 2'b00;
        if (mir == 4'b0001) return 2'b01;
        if (mir == 4'b0010) return 2'b10;
        return 2'b11;
    endfunction

    task automatic check_model(input string tag);
        check({tag, ".tlr"},  32'(tlr),  32'(ms == M_TLR));
        check({tag, ".cap"},  32'(cap),  32'(ms == M_CAP_DR));
        check({tag, ".shdr"}, 32'(shdr), 32'(ms == M_SH_DR));
        check({tag, ".upd"},  32'(upd),  32'(ms == M_UPD_DR));
        check({tag, ".irsh"}, 32'(irsh), 32'(ms == M_SH_IR));
        check({tag, ".tdo"},  32'(tdo),  32'(msreg[0]));
        check({tag, ".sel"},  32'(sel),  32'(model_sel()));
        check({tag, ".ir"},   32'(ir),   32'(mir));
    endtask

    task automatic step(input logic t, input logic d);
        tms = t;
        tdi = d;
        @(posedge clk);
        model_clock(t, d);
        #1;
    endtask

    typedef struct {
        logic       tms, tdi;
        logic       tlr, cap, shdr, upd, irsh, tdo;
        logic [1:0] sel;
        logic [3:0] ir;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic t, input logic d, input logic e_tlr, input logic e_cap,
                       input logic e_shdr, input logic e_upd, input logic e_irsh,
                       input logic e_tdo, input logic [1:0] e_sel, input logic [3:0] e_ir);
        vec_t v;
        v.tms = t; v.tdi = d; v.tlr = e_tlr; v.cap = e_cap; v.shdr = e_shdr;
        v.upd = e_upd; v.irsh = e_irsh; v.tdo = e_tdo; v.sel = e_sel; v.ir = e_ir;
        vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1;
        tms = 1'b1;
        tdi = 1'b0;
        model_reset();

        // Path from reset through a DR scan, then load SCAN and an undefined opcode.
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(0, 0, 0, 1, 0, 0, 0, 0, RST_SEL, RST_OP);
        add(0, 0, 0, 0, 1, 0, 0, 0, RST_SEL, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, RST_SEL, RST_OP);
        add(1, 0, 0, 0, 0, 1, 0, 0, RST_SEL, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, RST_OP);
        add(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, RST_OP);
        add(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, RST_OP);
        add(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, RST_OP);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(0, 0, 0, 1, 0, 0, 0, 0, 2'b10, 4'b0010);
        add(0, 0, 0, 0, 1, 0, 0, 0, 2'b10, 4'b0010);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b10, 4'b0010);
        add(1, 0, 0, 0, 0, 1, 0, 0, 2'b10, 4'b0010);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(0, 0, 0, 0, 0, 0, 1, 1, 2'b00, 4'b0010);
        add(0, 0, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0010);
        add(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0010);
        add(0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 4'b0010);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0010);
        add(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0110);
        add(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 4'b0110);
        add(0, 0, 0, 1, 0, 0, 0, 0, 2'b11, 4'b0110);
        add(0, 0, 0, 0, 1, 0, 0, 0, 2'b11, 4'b0110);

        #12;
        rst = 1'b0;
        check("rst.tlr",  32'(tlr),  32'd1);
        check("rst.sel",  32'(sel),  32'd0);
        check("rst.cap",  32'(cap),  32'd0);
        check("rst.shdr", 32'(shdr), 32'd0);
        check("rst.upd",  32'(upd),  32'd0);
        check("rst.irsh", 32'(irsh), 32'd0);
        check("rst.tdo",  32'(tdo),  32'd0);
        check("rst.ir",   32'(ir),   32'(RST_OP));

        foreach (vecs[i]) begin
            step(vecs[i].tms, vecs[i].tdi);
            check($sformatf("vec%0d.tlr", i),  32'(tlr),  32'(vecs[i].tlr));
            check($sformatf("vec%0d.cap", i),  32'(cap),  32'(vecs[i].cap));
            check($sformatf("vec%0d.shdr", i), 32'(shdr), 32'(vecs[i].shdr));
            check($sformatf("vec%0d.upd", i),  32'(upd),  32'(vecs[i].upd));
            check($sformatf("vec%0d.irsh", i), 32'(irsh), 32'(vecs[i].irsh));
            check($sformatf("vec%0d.tdo", i),  32'(tdo),  32'(vecs[i].tdo));
            check($sformatf("vec%0d.sel", i),  32'(sel),  32'(vecs[i].sel));
            check($sformatf("vec%0d.ir", i),   32'(ir),   32'(vecs[i].ir));
        end

        // SH_DR -> SH_IR, shift one bit, then detour EX1/PA/EX2 back into SH_IR.
        step(1, 0); step(1, 0); step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        check_model("toshir");
        step(0, 1); check_model("shift1");
        step(1, 0); check_model("ex1ir");
        step(0, 0); check_model("pair");
        step(1, 0); check_model("ex2ir");
        step(0, 0); check_model("backshir");
        check("backshir.irsh", 32'(irsh), 32'd1);

        // Five TMS=1 edges from mid-shift must land in TLR with the reset opcode.
        step(0, 1); check_model("midshift");
        for (int k = 0; k < 5; k++) step(1, 1);
        check_model("tms5");
        check("tms5.tlr", 32'(tlr), 32'd1);
        check("tms5.ir",  32'(ir),  32'(RST_OP));

        // Asynchronous reset between edges while in SH_DR.
        step(0, 0); step(1, 0); step(0, 0); step(0, 0);
        check("ashdr.shdr", 32'(shdr), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst.shdr", 32'(shdr), 32'd0);
        check("arst.sel",  32'(sel),  32'd0);
        check("arst.tlr",  32'(tlr),  32'd1);
        check("arst.ir",   32'(ir),   32'(RST_OP));
        check("arst.tdo",  32'(tdo),  32'd0);
        rst = 1'b0;
        model_reset();

        for (int n = 0; n < 2000; n++) begin
            step(($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 149) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
                model_reset();
                check_model("rnd_rst");
            end else begin
                check_model("rnd");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pb_tap_ctrl.md
Name: pb_tap_ctrl

Overview:
- IEEE 1149.1 TAP controller for the debug port.
- Runs the 16-state TAP FSM on TMS and holds the instruction register (IR).
- Decodes the IR into the 2-bit select for pb_dr_mux (01 = DR/IDCODE, 10 = scan chain, 11 = bypass, 00 = forced 0).
- Also gives DR capture/shift/update strobes to the data registers, and a serial IR output for the top-level TDO path.

Parameters:
- IR_WIDTH, 4, instruction register width (>= 2).
- IDCODE_INSTR, 4'b0001, opcode that selects the IDCODE DR (sel 01).
- SCAN_INSTR, 4'b0010, opcode that selects the scan chain (sel 10).
- BYPASS_INSTR, 4'b1111, bypass opcode (sel 11). Every undefined opcode also decodes to bypass.

Ports:
- clk_i  in  1  TCK; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset (TRST equivalent).
- tms_i  in  1  test mode select.
- tdi_i  in  1  test data in, shifted into the IR in Shift-IR.
- sel_o  out  2  pb_dr_mux select.
- capture_dr_o  out  1  high while state is Capture-DR.
- shift_dr_o  out  1  high while state is Shift-DR.
- update_dr_o  out  1  high while state is Update-DR.
- tlr_o  out  1  high while state is Test-Logic-Reset.
- ir_shift_o  out  1  high while state is Shift-IR; top level routes ir_tdo_o to TDO.
- ir_tdo_o  out  1  IR shift register LSB.
- ir_o  out  IR_WIDTH  active (updated) instruction.

Behaviour:
- FSM states: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- Transitions (TMS=0 / TMS=1):
  - TLR: RTI / TLR
  - RTI: RTI / SEL_DR
  - SEL_DR: CAP_DR / SEL_IR
  - CAP_DR: SH_DR / EX1_DR
  - SH_DR: SH_DR / EX1_DR
  - EX1_DR: PA_DR / UPD_DR
  - PA_DR: PA_DR / EX2_DR
  - EX2_DR: SH_DR / UPD_DR
  - UPD_DR: RTI / SEL_DR
  - SEL_IR: CAP_IR / TLR
  - IR side mirrors DR side: CAP_IR, SH_IR, EX1_IR, PA_IR, EX2_IR, UPD_IR.
- rst_i high: asynchronous return to TLR. ir_o = reset opcode (see Optional Feature). IR shift register = all zeros.
- Five consecutive TMS=1 edges reach TLR from any state.
- Entering TLR through TMS also loads ir_o with the reset opcode on that same edge.
- CAP_IR: shift register loads {zeros, 2'b01} (LSBs 01 per 1149.1).
- SH_IR: each edge does shift right; tdi_i enters the MSB. ir_tdo_o = sreg[0], combinational from the register.
- UPD_IR: on the edge that leaves UPD_IR, ir_o <= sreg. ir_o is unchanged in every other state.
- Status outputs are pure decodes of the state register (Moore, no extra latency).
- sel_o:
  - SH_DR, CAP_DR, EX1_DR, PA_DR, EX2_DR, UPD_DR: decode of ir_o (IDCODE_INSTR -> 01, SCAN_INSTR -> 10, else -> 11).
  - All other states: 00.
- Reset values: sel_o=00, tlr_o=1, all strobes 0, ir_shift_o=0, ir_tdo_o=0.
- rst_i asserted mid-shift: the partial IR is discarded and ir_o takes the reset opcode.
- Leaving SH_IR through EX1_IR then EX2_IR back to SH_IR keeps the shift register contents.

Optional Feature:
- Macro PB_TAP_IDCODE_DEFAULT_EN.
- Defined: reset opcode = IDCODE_INSTR, so sel_o=01 in DR states after reset (1149.1 IDCODE default).
- Undefined: reset opcode = BYPASS_INSTR, so sel_o=11 after reset.

Decomposition:
- Package pb_tap_pkg holds:
  - tap_state_e, a 4-bit enum of the 16 states;
  - tdo_sel_e (SEL_ZERO=00, SEL_DR=01, SEL_SCAN=10, SEL_BYP=11), shared with pb_dr_mux;
  - the default opcode constants.
- One sub-module, pb_tap_ir: capture/shift/update register plus opcode decode to tdo_sel_e.
- The FSM stays in pb_tap_ctrl.

Test Plan:
- Reset, then TMS 0 -> tlr_o 1 -> 0, state RTI, sel_o=00. ir_o=0001 with the macro, 1111 without.
- From RTI, TMS 1,0,0 (enter SH_DR) -> capture_dr_o high one cycle, then shift_dr_o=1, sel_o=01 (macro on).
- Load SCAN via IR:
  - from RTI, TMS 1,1,0,0 reaches SH_IR;
  - shift TDI 0,1,0,0 with TMS=1 on the last bit, then TMS 1;
  - expect ir_tdo_o = 1,0,0,0 (captured 0001), ir_o=0010 after UPD_IR, sel_o=10 in the next SH_DR.
- Shift opcode 0110 (undefined) -> ir_o=0110, sel_o=11 in SH_DR, 00 in RTI.
- From SH_IR mid-shift, TMS=1 for 5 edges -> tlr_o=1, ir_o = reset opcode, partial IR discarded.
- Assert rst_i asynchronously between edges while in SH_DR -> shift_dr_o and sel_o drop to 0 immediately, tlr_o=1 before the next clk_i edge.
